v_sequential_load: RTL and testbench
====================================

Name: v_sequential_load

Overview:
- Load-side counterpart of the sequential store path in the VLSU.
- Consumes AXI R beats for unit-stride (sequential) vector loads and packs their valid nibbles into DLEN*NrExits-wide sequential entries, one entry per commit to the ShuffleUnit.
- Beat windows come from the per-beat txn_ctrl stream. The start offset of the first entry comes from the per-request meta (vstart, sew).
- Sits between the AXI R channel and the ShuffleUnit.

Parameters:
- NrExits, 1, number of lane exits per sequential entry.
- Dlen, riva_pkg::DLEN (64), lane datapath width in bits.
- AxiDataWidth, 64, AXI R data width in bits.
- SeqInfoDep, 2, depth of the per-request start-offset queue.
- OutDep, 2, depth of the output entry queue.
- NrLaneEntriesNbs (derived, do not override), Dlen/4*NrExits, nibbles per entry.
- busNibbles (derived, do not override), AxiDataWidth/4.
- busNSize (derived, do not override), log2(busNibbles).

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset, synchronous, active-low.
- axi_r_valid_i  in  1  R beat valid.
- axi_r_ready_o  out  1  R beat ready.
- axi_r_data_i  in  AxiDataWidth  R data.
- axi_r_last_i  in  1  R last.
- txn_ctrl_valid_i  in  1  per-beat control valid.
- txn_ctrl_ready_o  out  1  per-beat control ready.
- txn_addr_i  in  busNSize  low address nibble bits.
- txn_is_head_i  in  1  first beat of the AXI txn.
- txn_rmn_beat_i  in  8  remaining beats after this one.
- txn_lbn_i  in  busNSize+1  valid upper nibble bound of the last beat.
- txn_is_final_i  in  1  last AXI txn of the vector request.
- meta_glb_valid_i  in  1  request meta valid.
- meta_glb_ready_o  out  1  request meta ready.
- meta_vstart_i  in  riva_pkg::ELEN  vstart in elements.
- meta_sew_i  in  2  log2(element bytes).
- tx_shfu_valid_o  out  1  entry valid to the ShuffleUnit.
- tx_shfu_ready_i  in  1  ShuffleUnit ready.
- tx_shfu_nb_o  out  4*NrLaneEntriesNbs  entry nibbles.
- tx_shfu_en_o  out  NrLaneEntriesNbs  nibble enables.

Behaviour:
Reset:
- Synchronous, active-low; there is no asynchronous path.
- State goes to S_IDLE; all pointers and counters, both queues and the accumulator are cleared.
- While rst_ni=0, all outputs are 0.
- Reset asserted mid-request drops all in-flight data; no partial entry is emitted afterwards.

Start-offset queue:
- meta_glb_ready_o = !seq_info_full.
- On a meta handshake, push seq_nb_ptr = (vstart << (sew+1)) mod NrLaneEntriesNbs.

FSM:
- S_IDLE: if txn_ctrl_valid_i && seq_info not empty, then:
  - seq_nb_ptr ← head of the queue, bus_nb_cnt ← 0;
  - pop the queue;
  - go to S_SERIAL.
  - No beat is consumed in this cycle.
- S_SERIAL: a commit is allowed when axi_r_valid_i && txn_ctrl_valid_i && !out_full. Per commit:
  - lower = txn_is_head_i ? txn_addr_i : 0;
  - upper = (txn_rmn_beat_i == 0) ? txn_lbn_i : busNibbles;
  - bus_valid = upper − lower − bus_nb_cnt;
  - seq_free = NrLaneEntriesNbs − seq_nb_ptr;
  - start = lower + bus_nb_cnt.
- Case bus_valid > seq_free:
  - copy seq_free nibbles: bus[start+k] → acc[seq_nb_ptr+k], and set en;
  - push acc to the output queue; acc ← 0;
  - bus_nb_cnt += seq_free; seq_nb_ptr ← 0;
  - do not consume the beat.
- Otherwise:
  - copy bus_valid nibbles; seq_nb_ptr += bus_valid; bus_nb_cnt ← 0;
  - axi_r_ready_o = txn_ctrl_ready_o = 1 in the same cycle (they are always equal);
  - if bus_valid == seq_free, or this is the final beat (txn_is_final_i && txn_rmn_beat_i == 0), push acc and set seq_nb_ptr ← 0.
- A final-beat handshake returns the FSM to S_IDLE.

Output and ordering:
- Nibbles before the start offset in the first entry have en=0. Nibbles after the final data in the last entry have en=0.
- Output queue is registered: a pushed entry appears on tx_shfu_* in the next cycle. tx_shfu_valid_o = !out_empty.
- A push and a pop in the same cycle are allowed when the queue is full-1 or not empty.
- Entries leave in commit order; backpressure never drops or reorders data.

Widths and assertions:
- Arithmetic is done at busNSize+1 and log2(NrLaneEntriesNbs)+1 bits.
- Assert upper ≤ busNibbles.
- Assert bus_valid ≤ busNibbles.
- Assert axi_r_last_i == (txn_rmn_beat_i == 0) on every R handshake.

Decomposition:
- vlsu_pkg holds the seq_info_t and seq_buf_t (nb, en) types and the OutDep/SeqInfoDep defaults.
- Reuse QueueFlow for both the start-offset queue and the output queue.
- Reuse CircularQueuePtrTemplate for pointers.
- No new sub-module.

Test Plan:
(All cases use AxiDataWidth=64 and Dlen=64, so 16 bus nibbles and 16 entry nibbles.)
- Aligned single beat: vstart=0, head, addr=0, rmn=0, lbn=16, final, data=0x0123456789ABCDEF → one entry with nb=data, en=0xFFFF, valid 1 cycle after the R handshake; FSM back in S_IDLE.
- Misaligned two-beat request: addr=4, beat0 rmn=1, beat1 rmn=0, lbn=4 → beat0 nibbles 4..15 land in entry 0..11; beat1 nibbles 0..3 land in entry 12..15; exactly one entry, en=0xFFFF.
- vstart offset: vstart=2, sew=1 (start ptr=8), one full final beat →
  - entry 1: nibbles 0..7 in slots 8..15, en=0xFF00, R not yet consumed;
  - entry 2 (next cycle): nibbles 8..15 in slots 0..7, en=0x00FF;
  - R consumed in the second cycle.
- Backpressure: tx_shfu_ready_i=0 across a 3-entry request → axi_r_ready_o stays low once 2 entries are queued; after releasing ready, all 3 entries arrive in order, unaltered.
- Meta queue: two metas (vstart 0, then vstart 4 with sew=0) sent before any beats → the second request's first entry has en=0xFF00.
- Reset mid-request: assert rst_ni=0 after the first beat of the two-beat case → next cycle tx_shfu_valid_o=0 and state is S_IDLE; a fresh request then behaves as in the aligned single-beat case.

Source files
------------

// File: rtl/riva_pkg.sv
// Global vector datapath constants shared across the RIVA core.
package riva_pkg;
   localparam int unsigned DLEN = 64;
   localparam int unsigned ELEN = 64;
endpackage

// File: rtl/vlsu_pkg.sv
// VLSU shared types: FSM states, start-offset record and sequential entry.
package vlsu_pkg;
   localparam int unsigned SeqInfoDepDef = 2;
   localparam int unsigned OutDepDef     = 2;
   localparam int unsigned SeqNbsDef     = riva_pkg::DLEN / 4;

   typedef enum logic {
      S_IDLE,
      S_SERIAL
   } seq_state_e;

   typedef struct packed {
      logic [$clog2(SeqNbsDef)-1:0] seq_nb_ptr;
   } seq_info_t;

   typedef struct packed {
      logic [4*SeqNbsDef-1:0] nb;
      logic [SeqNbsDef-1:0]   en;
   } seq_buf_t;
endpackage

// File: rtl/CircularQueuePtrTemplate.sv
// Wrapping queue pointer; the flag toggles on every wrap to tell full from empty.
module CircularQueuePtrTemplate #(
   parameter  int unsigned Depth = 2,
   localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          inc_i,
   output logic [AW-1:0] idx_o,
   output logic          flag_o
);
   logic [AW-1:0] idx_q;
   logic          flag_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         idx_q  <= '0;
         flag_q <= 1'b0;
      end else if (inc_i) begin
         if (idx_q == AW'(Depth - 1)) begin
            idx_q  <= '0;
            flag_q <= ~flag_q;
         end else begin
            idx_q <= idx_q + AW'(1);
         end
      end
   end

   assign idx_o  = idx_q;
   assign flag_o = flag_q;
endmodule

// File: rtl/QueueFlow.sv
// Registered FIFO; pushes while full and pops while empty are ignored.
module QueueFlow #(
   parameter  int unsigned Depth = 2,
   parameter  type         T     = logic,
   localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);
   T              mem_q [Depth];
   logic [AW-1:0] wr_idx, rd_idx;
   logic          wr_flag, rd_flag;
   logic          push_en, pop_en;

   assign full_o  = (wr_idx == rd_idx) && (wr_flag != rd_flag);
   assign empty_o = (wr_idx == rd_idx) && (wr_flag == rd_flag);
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;

   CircularQueuePtrTemplate #(.Depth(Depth)) u_wr_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (push_en),
      .idx_o  (wr_idx),
      .flag_o (wr_flag)
   );

   CircularQueuePtrTemplate #(.Depth(Depth)) u_rd_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (pop_en),
      .idx_o  (rd_idx),
      .flag_o (rd_flag)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
      end else if (push_en) begin
         mem_q[wr_idx] <= data_i;
      end
   end

   assign data_o = mem_q[rd_idx];
endmodule

// File: rtl/v_sequential_load.sv
// Unit-stride load path: packs valid nibbles of AXI R beats into sequential
// entries for the ShuffleUnit, starting at the per-request vstart offset.
module v_sequential_load
   import vlsu_pkg::*;
#(
   parameter  int unsigned NrExits          = 1,
   parameter  int unsigned Dlen             = riva_pkg::DLEN,
   parameter  int unsigned AxiDataWidth     = 64,
   parameter  int unsigned SeqInfoDep       = SeqInfoDepDef,
   parameter  int unsigned OutDep           = OutDepDef,
   localparam int unsigned NrLaneEntriesNbs = Dlen / 4 * NrExits,
   localparam int unsigned busNibbles       = AxiDataWidth / 4,
   localparam int unsigned busNSize         = $clog2(busNibbles)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          axi_r_valid_i,
   output logic                          axi_r_ready_o,
   input  logic [AxiDataWidth-1:0]       axi_r_data_i,
   input  logic                          axi_r_last_i,
   input  logic                          txn_ctrl_valid_i,
   output logic                          txn_ctrl_ready_o,
   input  logic [busNSize-1:0]           txn_addr_i,
   input  logic                          txn_is_head_i,
   input  logic [7:0]                    txn_rmn_beat_i,
   input  logic [busNSize:0]             txn_lbn_i,
   input  logic                          txn_is_final_i,
   input  logic                          meta_glb_valid_i,
   output logic                          meta_glb_ready_o,
   input  logic [riva_pkg::ELEN-1:0]     meta_vstart_i,
   input  logic [1:0]                    meta_sew_i,
   output logic                          tx_shfu_valid_o,
   input  logic                          tx_shfu_ready_i,
   output logic [4*NrLaneEntriesNbs-1:0] tx_shfu_nb_o,
   output logic [NrLaneEntriesNbs-1:0]   tx_shfu_en_o
);
   localparam int unsigned BW = busNSize + 1;
   localparam int unsigned SW = $clog2(NrLaneEntriesNbs) + 1;
   localparam int unsigned PW = SW - 1;

   seq_state_e    state_q, state_d;
   logic [SW-1:0] seq_nb_ptr_q, seq_nb_ptr_d;
   logic [BW-1:0] bus_nb_cnt_q, bus_nb_cnt_d;
   seq_buf_t      acc_q, acc_d, acc_merged;

   seq_info_t     info_in, info_out;
   logic          info_full, info_empty, info_push, info_pop;
   seq_buf_t      out_data;
   logic          out_full, out_empty, out_push, out_pop;

   logic [BW-1:0] lower, upper, bus_valid, start;
   logic [SW-1:0] seq_free;
   logic [31:0]   n_copy;
   logic          spill, final_beat, commit, beat_ack;

   // Start offset in nibbles: one element is 2^(sew+1) nibbles.
   assign info_in.seq_nb_ptr = PW'(meta_vstart_i << ({1'b0, meta_sew_i} + 3'd1));
   assign meta_glb_ready_o   = rst_ni && !info_full;
   assign info_push          = meta_glb_valid_i && meta_glb_ready_o;

   QueueFlow #(.Depth(SeqInfoDep), .T(seq_info_t)) u_seq_info_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (info_push),
      .data_i  (info_in),
      .pop_i   (info_pop),
      .data_o  (info_out),
      .full_o  (info_full),
      .empty_o (info_empty)
   );

   assign lower      = txn_is_head_i ? {1'b0, txn_addr_i} : '0;
   assign upper      = (txn_rmn_beat_i == 8'd0) ? txn_lbn_i : BW'(busNibbles);
   assign bus_valid  = upper - lower - bus_nb_cnt_q;
   assign seq_free   = SW'(NrLaneEntriesNbs) - seq_nb_ptr_q;
   assign start      = lower + bus_nb_cnt_q;
   assign spill      = 32'(bus_valid) > 32'(seq_free);
   assign n_copy     = spill ? 32'(seq_free) : 32'(bus_valid);
   assign final_beat = txn_is_final_i && (txn_rmn_beat_i == 8'd0);
   assign commit     = (state_q == S_SERIAL) && axi_r_valid_i && txn_ctrl_valid_i && !out_full;

   always_comb begin
      logic [31:0] src;
      acc_merged = acc_q;
      src        = '0;
      for (int unsigned j = 0; j < NrLaneEntriesNbs; j++) begin
         if (j >= 32'(seq_nb_ptr_q) && j < 32'(seq_nb_ptr_q) + n_copy) begin
            src                     = 32'(start) + j - 32'(seq_nb_ptr_q);
            acc_merged.nb[4*j +: 4] = axi_r_data_i[4*src +: 4];
            acc_merged.en[j]        = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      seq_nb_ptr_d = seq_nb_ptr_q;
      bus_nb_cnt_d = bus_nb_cnt_q;
      acc_d        = acc_q;
      info_pop     = 1'b0;
      out_push     = 1'b0;
      beat_ack     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (txn_ctrl_valid_i && !info_empty) begin
               seq_nb_ptr_d = SW'(info_out.seq_nb_ptr);
               bus_nb_cnt_d = '0;
               acc_d        = '0;
               info_pop     = 1'b1;
               state_d      = S_SERIAL;
            end
         end
         S_SERIAL: begin
            if (commit) begin
               if (spill) begin
                  // Entry fills before the beat is exhausted: emit it and
                  // keep the beat, resuming from bus_nb_cnt next cycle.
                  out_push     = 1'b1;
                  acc_d        = '0;
                  bus_nb_cnt_d = bus_nb_cnt_q + BW'(seq_free);
                  seq_nb_ptr_d = '0;
               end else begin
                  beat_ack     = 1'b1;
                  acc_d        = acc_merged;
                  bus_nb_cnt_d = '0;
                  seq_nb_ptr_d = seq_nb_ptr_q + SW'(bus_valid);
                  if (32'(bus_valid) == 32'(seq_free) || final_beat) begin
                     out_push     = 1'b1;
                     acc_d        = '0;
                     seq_nb_ptr_d = '0;
                  end
                  if (final_beat) begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         seq_nb_ptr_q <= '0;
         bus_nb_cnt_q <= '0;
         acc_q        <= '0;
      end else begin
         state_q      <= state_d;
         seq_nb_ptr_q <= seq_nb_ptr_d;
         bus_nb_cnt_q <= bus_nb_cnt_d;
         acc_q        <= acc_d;
      end
   end

   QueueFlow #(.Depth(OutDep), .T(seq_buf_t)) u_out_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (out_push),
      .data_i  (acc_merged),
      .pop_i   (out_pop),
      .data_o  (out_data),
      .full_o  (out_full),
      .empty_o (out_empty)
   );

   assign axi_r_ready_o    = rst_ni && beat_ack;
   assign txn_ctrl_ready_o = rst_ni && beat_ack;
   assign tx_shfu_valid_o  = rst_ni && !out_empty;
   assign out_pop          = tx_shfu_valid_o && tx_shfu_ready_i;
   assign tx_shfu_nb_o     = rst_ni ? out_data.nb : '0;
   assign tx_shfu_en_o     = rst_ni ? out_data.en : '0;

   always_ff @(posedge clk_i) begin
      if (rst_ni && commit) begin
         assert (32'(upper) <= busNibbles);
         assert (32'(bus_valid) <= busNibbles);
      end
      if (rst_ni && axi_r_valid_i && axi_r_ready_o) begin
         assert (axi_r_last_i == (txn_rmn_beat_i == 8'd0));
      end
   end
endmodule

// File: tb/tb_v_sequential_load.sv
// Directed bench for v_sequential_load with 16 bus nibbles and 16 entry nibbles.
module tb_v_sequential_load;
   import vlsu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        axi_r_valid_i = 1'b0;
   logic        axi_r_ready_o;
   logic [63:0] axi_r_data_i = '0;
   logic        axi_r_last_i = 1'b0;
   logic        txn_ctrl_valid_i = 1'b0;
   logic        txn_ctrl_ready_o;
   logic [3:0]  txn_addr_i = '0;
   logic        txn_is_head_i = 1'b0;
   logic [7:0]  txn_rmn_beat_i = '0;
   logic [4:0]  txn_lbn_i = '0;
   logic        txn_is_final_i = 1'b0;
   logic        meta_glb_valid_i = 1'b0;
   logic        meta_glb_ready_o;
   logic [63:0] meta_vstart_i = '0;
   logic [1:0]  meta_sew_i = '0;
   logic        tx_shfu_valid_o;
   logic        tx_shfu_ready_i = 1'b1;
   logic [63:0] tx_shfu_nb_o;
   logic [15:0] tx_shfu_en_o;

   int checks = 0;
   int failures = 0;
   logic [79:0] got_q [$];

   localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;

   v_sequential_load #(
      .NrExits      (1),
      .Dlen         (64),
      .AxiDataWidth (64),
      .SeqInfoDep   (2),
      .OutDep       (2)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .axi_r_valid_i    (axi_r_valid_i),
      .axi_r_ready_o    (axi_r_ready_o),
      .axi_r_data_i     (axi_r_data_i),
      .axi_r_last_i     (axi_r_last_i),
      .txn_ctrl_valid_i (txn_ctrl_valid_i),
      .txn_ctrl_ready_o (txn_ctrl_ready_o),
      .txn_addr_i       (txn_addr_i),
      .txn_is_head_i    (txn_is_head_i),
      .txn_rmn_beat_i   (txn_rmn_beat_i),
      .txn_lbn_i        (txn_lbn_i),
      .txn_is_final_i   (txn_is_final_i),
      .meta_glb_valid_i (meta_glb_valid_i),
      .meta_glb_ready_o (meta_glb_ready_o),
      .meta_vstart_i    (meta_vstart_i),
      .meta_sew_i       (meta_sew_i),
      .tx_shfu_valid_o  (tx_shfu_valid_o),
      .tx_shfu_ready_i  (tx_shfu_ready_i),
      .tx_shfu_nb_o     (tx_shfu_nb_o),
      .tx_shfu_en_o     (tx_shfu_en_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (tx_shfu_valid_o && tx_shfu_ready_i) got_q.push_back({tx_shfu_nb_o, tx_shfu_en_o});
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [79:0] entry(input int i);
      return (got_q.size() > i) ? got_q[i] : 'x;
   endfunction

   task automatic send_meta(input logic [63:0] vstart, input logic [1:0] sew);
      meta_glb_valid_i = 1'b1;
      meta_vstart_i    = vstart;
      meta_sew_i       = sew;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (meta_glb_ready_o) begin
            @(posedge clk_i); #1;
            meta_glb_valid_i = 1'b0;
            return;
         end
      end
      checks++; failures++;
      $display("FAIL meta_timeout ready=%b required=1", meta_glb_ready_o);
      meta_glb_valid_i = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic head, input logic [3:0] addr,
                            input logic [7:0] rmn, input logic [4:0] lbn, input logic fin,
                            output int waits);
      axi_r_valid_i    = 1'b1;
      txn_ctrl_valid_i = 1'b1;
      axi_r_data_i     = d;
      axi_r_last_i     = (rmn == 8'd0);
      txn_is_head_i    = head;
      txn_addr_i       = addr;
      txn_rmn_beat_i   = rmn;
      txn_lbn_i        = lbn;
      txn_is_final_i   = fin;
      waits = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (axi_r_ready_o) begin
            @(posedge clk_i); #1;
            axi_r_valid_i    = 1'b0;
            txn_ctrl_valid_i = 1'b0;
            return;
         end
         waits++;
      end
      checks++; failures++;
      $display("FAIL beat_timeout ready=%b required=1", axi_r_ready_o);
      axi_r_valid_i    = 1'b0;
      txn_ctrl_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      meta_glb_valid_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if ({axi_r_ready_o, txn_ctrl_ready_o, meta_glb_ready_o, tx_shfu_valid_o, tx_shfu_nb_o, tx_shfu_en_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs valid=%b meta_rdy=%b r_rdy=%b required all 0", tx_shfu_valid_o, meta_glb_ready_o, axi_r_ready_o);
      end
      meta_glb_valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if (meta_glb_ready_o !== 1'b1 || tx_shfu_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_release meta_rdy=%b valid=%b required 1/0", meta_glb_ready_o, tx_shfu_valid_o);
      end
      checks++;
      if (dut.state_q !== S_IDLE) begin
         failures++;
         $display("FAIL reset_state got=%0d required=%0d", dut.state_q, S_IDLE);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_aligned;
      int w;
      got_q.delete();
      send_meta(64'd0, 2'd0);
      send_beat(D0, 1'b1, 4'd0, 8'd0, 5'd16, 1'b1, w);
      checks++;
      if (w != 1) begin failures++; $display("FAIL aligned_wait got=%0d required=1", w); end
      checks++;
      if (tx_shfu_valid_o !== 1'b1) begin failures++; $display("FAIL aligned_latency valid=%b required=1", tx_shfu_valid_o); end
      checks++;
      if (dut.state_q !== S_IDLE) begin failures++; $display("FAIL aligned_idle state=%0d required=%0d", dut.state_q, S_IDLE); end
      repeat (2) @(negedge clk_i);
      checks++;
      if (got_q.size() != 1) begin failures++; $display("FAIL aligned_count got=%0d required=1", got_q.size()); end
      checks++;
      if (entry(0) !== {D0, 16'hFFFF}) begin failures++; $display("FAIL aligned_entry got=%h required=%h", entry(0), {D0, 16'hFFFF}); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_misaligned;
      int w0, w1;
      got_q.delete();
      send_meta(64'd0, 2'd0);
      send_beat(D0, 1'b1, 4'd4, 8'd1, 5'd16, 1'b0, w0);
      send_beat(D1, 1'b0, 4'd0, 8'd0, 5'd4, 1'b1, w1);
      checks++;
      if (w0 != 1 || w1 != 0) begin failures++; $display("FAIL misaligned_wait got=%0d/%0d required=1/0", w0, w1); end
      repeat (2) @(negedge clk_i);
      checks++;
      if (got_q.size() != 1) begin failures++; $display("FAIL misaligned_count got=%0d required=1", got_q.size()); end
      checks++;
      if (entry(0) !== {64'h3210_0123_4567_89AB, 16'hFFFF}) begin
         failures++; $display("FAIL misaligned_entry got=%h required=%h", entry(0), {64'h3210_0123_4567_89AB, 16'hFFFF});
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_vstart;
      int w;
      got_q.delete();
      send_meta(64'd2, 2'd1);
      send_beat(D0, 1'b1, 4'd0, 8'd0, 5'd16, 1'b1, w);
      checks++;
      if (w != 2) begin failures++; $display("FAIL vstart_wait got=%0d required=2", w); end
      repeat (2) @(negedge clk_i);
      checks++;
      if (got_q.size() != 2) begin failures++; $display("FAIL vstart_count got=%0d required=2", got_q.size()); end
      checks++;
      if (entry(0) !== {64'h89AB_CDEF_0000_0000, 16'hFF00}) begin
         failures++; $display("FAIL vstart_entry1 got=%h required=%h", entry(0), {64'h89AB_CDEF_0000_0000, 16'hFF00});
      end
      checks++;
      if (entry(1) !== {64'h0000_0000_0123_4567, 16'h00FF}) begin
         failures++; $display("FAIL vstart_entry2 got=%h required=%h", entry(1), {64'h0000_0000_0123_4567, 16'h00FF});
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_backpressure;
      int wa, wb, wc;
      got_q.delete();
      tx_shfu_ready_i = 1'b0;
      send_meta(64'd0, 2'd0);
      send_beat(D0, 1'b1, 4'd0, 8'd2, 5'd16, 1'b1, wa);
      send_beat(D1, 1'b0, 4'd0, 8'd1, 5'd16, 1'b1, wb);
      fork
         send_beat(D2, 1'b0, 4'd0, 8'd0, 5'd16, 1'b1, wc);
         begin
            repeat (4) @(negedge clk_i);
            checks++;
            if (axi_r_ready_o !== 1'b0) begin failures++; $display("FAIL bp_r_stall ready=%b required=0", axi_r_ready_o); end
            checks++;
            if (tx_shfu_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid_held valid=%b required=1", tx_shfu_valid_o); end
            @(posedge clk_i); #1;
            tx_shfu_ready_i = 1'b1;
         end
      join
      checks++;
      if (wa != 1 || wb != 0 || wc != 5) begin failures++; $display("FAIL bp_wait got=%0d/%0d/%0d required=1/0/5", wa, wb, wc); end
      repeat (4) @(negedge clk_i);
      checks++;
      if (got_q.size() != 3) begin failures++; $display("FAIL bp_count got=%0d required=3", got_q.size()); end
      checks++;
      if (entry(0) !== {D0, 16'hFFFF} || entry(1) !== {D1, 16'hFFFF} || entry(2) !== {D2, 16'hFFFF}) begin
         failures++; $display("FAIL bp_order got=%h,%h,%h required data D0,D1,D2 en ffff", entry(0), entry(1), entry(2));
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_meta_queue;
      int w;
      got_q.delete();
      send_meta(64'd0, 2'd0);
      send_meta(64'd4, 2'd0);
      @(negedge clk_i);
      checks++;
      if (meta_glb_ready_o !== 1'b0) begin failures++; $display("FAIL meta_full ready=%b required=0", meta_glb_ready_o); end
      @(posedge clk_i); #1;
      send_beat(D0, 1'b1, 4'd0, 8'd0, 5'd16, 1'b1, w);
      send_beat(D1, 1'b1, 4'd0, 8'd0, 5'd16, 1'b1, w);
      repeat (2) @(negedge clk_i);
      checks++;
      if (meta_glb_ready_o !== 1'b1) begin failures++; $display("FAIL meta_drained ready=%b required=1", meta_glb_ready_o); end
      checks++;
      if (got_q.size() != 3) begin failures++; $display("FAIL metaq_count got=%0d required=3", got_q.size()); end
      checks++;
      if (entry(0) !== {D0, 16'hFFFF}) begin failures++; $display("FAIL metaq_entry0 got=%h required=%h", entry(0), {D0, 16'hFFFF}); end
      checks++;
      if (entry(1) !== {64'h7654_3210_0000_0000, 16'hFF00}) begin
         failures++; $display("FAIL metaq_entry1 got=%h required=%h", entry(1), {64'h7654_3210_0000_0000, 16'hFF00});
      end
      checks++;
      if (entry(2) !== {64'h0000_0000_FEDC_BA98, 16'h00FF}) begin
         failures++; $display("FAIL metaq_entry2 got=%h required=%h", entry(2), {64'h0000_0000_FEDC_BA98, 16'h00FF});
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset_mid;
      int w;
      got_q.delete();
      send_meta(64'd0, 2'd0);
      send_beat(D0, 1'b1, 4'd4, 8'd1, 5'd16, 1'b0, w);
      rst_ni = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({axi_r_ready_o, meta_glb_ready_o, tx_shfu_valid_o, tx_shfu_en_o} !== '0) begin
         failures++; $display("FAIL midrst_outputs meta_rdy=%b valid=%b required 0", meta_glb_ready_o, tx_shfu_valid_o);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      checks++;
      if (tx_shfu_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b required=0", tx_shfu_valid_o); end
      checks++;
      if (dut.state_q !== S_IDLE) begin failures++; $display("FAIL midrst_state got=%0d required=%0d", dut.state_q, S_IDLE); end
      repeat (3) @(negedge clk_i);
      checks++;
      if (got_q.size() != 0) begin failures++; $display("FAIL midrst_no_entry got=%0d required=0", got_q.size()); end
      @(posedge clk_i); #1;
      test_aligned();
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_misaligned();
      test_vstart();
      test_backpressure();
      test_meta_queue();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
